// File: rtl/dct8_sched.sv
// Row scheduler / flow controller for the 8-point DCT core: accept handshake, credit
// flow control, latency-matched output tagging. Optional stall counter via DCT8_SCHED_STATS_EN.
module dct8_sched #(
   parameter int unsigned LAT     = 2,
   parameter int unsigned ROWS    = 8,
   parameter int unsigned CREDITS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       core_load,
   output logic       m_valid,
   output logic [2:0] m_row,
   output logic       m_first,
   output logic       m_last,
   input  logic       m_credit,
   output logic       busy,
   output logic       blk_done,
   output logic       err_credit
`ifdef DCT8_SCHED_STATS_EN
  ,output logic [15:0] stall_cnt
`endif
);

   localparam int unsigned CW = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
   localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN} state_t;

   typedef struct packed {
      logic       vld;
      logic [2:0] row;
   } stage_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   credit_cnt;
   logic [2:0]      row_cnt;
   stage_t          pipe [LAT];
   logic            acc;
   logic            take_last;
   logic            pipe_busy;

   assign s_ready   = (credit_cnt != '0) & rst;
   assign acc       = s_valid & s_ready;
   assign core_load = acc;
   assign take_last = acc & (row_cnt == ROW_LAST);

   // Credit counter: an accept spends one entry, a returned credit refunds one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_cnt <= CRED_MAX;
         err_credit <= 1'b0;
      end else begin
         unique case ({acc, m_credit})
            2'b10: credit_cnt <= credit_cnt - CW'(1);
            2'b01: begin
               if (credit_cnt == CRED_MAX) err_credit <= 1'b1;
               else                        credit_cnt <= credit_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     row_cnt <= 3'd0;
      else if (acc) row_cnt <= (row_cnt == ROW_LAST) ? 3'd0 : row_cnt + 3'd1;
   end

   // Shadow of the core pipeline; the final stage lines up with y0..y7
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{vld: acc, row: row_cnt};
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < LAT; i++) pipe_busy = pipe_busy | pipe[i].vld;
   end

   assign m_valid  = pipe[LAT-1].vld;
   assign m_row    = pipe[LAT-1].row;
   assign m_first  = m_valid & (m_row == 3'd0);
   assign m_last   = m_valid & (m_row == ROW_LAST);
   assign blk_done = m_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next block's row 0 may be taken straight out of DRAIN without a bubble
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (acc) state_nxt = take_last ? DRAIN : ACCEPT;
         ACCEPT:  if (take_last) state_nxt = DRAIN;
         DRAIN: begin
            if (acc)             state_nxt = take_last ? DRAIN : ACCEPT;
            else if (!pipe_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

`ifdef DCT8_SCHED_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                          stall_cnt <= 16'd0;
      else if (blk_done)                                 stall_cnt <= 16'd0;
      else if (s_valid && !s_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_dct8_sched.sv
// Self-checking bench for dct8_sched: directed phases plus random traffic against a
// transaction-level model (credit count, accept timestamps, output due times).
module tb_dct8_sched;

   localparam int unsigned LAT     = 2;
   localparam int unsigned ROWS    = 8;
   localparam int unsigned CREDITS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s_valid = 1'b0;
   logic       m_credit = 1'b0;
   logic       s_ready, core_load, m_valid, m_first, m_last, busy, blk_done, err_credit;
   logic [2:0] m_row;
`ifdef DCT8_SCHED_STATS_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   dct8_sched #(.LAT(LAT), .ROWS(ROWS), .CREDITS(CREDITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .core_load  (core_load),
      .m_valid    (m_valid),
      .m_row      (m_row),
      .m_first    (m_first),
      .m_last     (m_last),
      .m_credit   (m_credit),
      .busy       (busy),
      .blk_done   (blk_done),
      .err_credit (err_credit)
`ifdef DCT8_SCHED_STATS_EN
     ,.stall_cnt  (stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: credits left, rows taken in current block, accepted (cycle,row) history
   int credits;
   int rows;
   int stall;
   bit err_m;
   bit busy_m;
   int q_cyc[$];
   int q_row[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic model_reset();
      credits = CREDITS;
      rows    = 0;
      stall   = 0;
      err_m   = 1'b0;
      busy_m  = 1'b0;
      q_cyc.delete();
      q_row.delete();
   endtask

   // Row accepted in cycle n is presented in cycle n+LAT
   function automatic bit out_due(output int row);
      row = 0;
      foreach (q_cyc[i]) if (q_cyc[i] == cyc - int'(LAT)) begin
         row = q_row[i];
         return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit in_flight();
      foreach (q_cyc[i]) if (q_cyc[i] >= cyc - int'(LAT) && q_cyc[i] <= cyc - 1) return 1'b1;
      return 1'b0;
   endfunction

   // mode: 0 no credit, 1 pulse, 2 echo expected m_valid, 3 random when entries outstanding
   task automatic step(input bit sv, input int mode);
      bit ev, rdy, acc, mc, fly;
      int er;
      @(posedge clk);
      cyc++;
      #1;
      ev  = out_due(er);
      rdy = (credits != 0);
      case (mode)
         0:       mc = 1'b0;
         1:       mc = 1'b1;
         2:       mc = ev;
         default: mc = (credits < int'(CREDITS)) && ($urandom_range(0, 2) == 0);
      endcase
      s_valid  = sv;
      m_credit = mc;
      acc = sv & rdy;
      #1;
      check("s_ready",    32'(s_ready),    32'(rdy));
      check("core_load",  32'(core_load),  32'(acc));
      check("m_valid",    32'(m_valid),    32'(ev));
      if (ev) check("m_row", 32'(m_row), 32'(er));
      check("m_first",    32'(m_first),    32'(ev && er == 0));
      check("m_last",     32'(m_last),     32'(ev && er == int'(ROWS) - 1));
      check("blk_done",   32'(blk_done),   32'(ev && er == int'(ROWS) - 1));
      check("busy",       32'(busy),       32'(busy_m));
      check("err_credit", 32'(err_credit), 32'(err_m));
`ifdef DCT8_SCHED_STATS_EN
      check("stall_cnt",  32'(stall_cnt),  32'(stall));
`endif
      fly = in_flight();
      if (acc && !mc) credits--;
      else if (mc && !acc) begin
         if (credits == int'(CREDITS)) err_m = 1'b1;
         else credits++;
      end
      if (acc) begin
         q_cyc.push_back(cyc);
         q_row.push_back(rows);
         rows = (rows + 1) % int'(ROWS);
      end
      busy_m = acc || (rows != 0) || fly;
      if (ev && er == int'(ROWS) - 1) stall = 0;
      else if (sv && !rdy && stall < 65535) stall++;
      while (q_cyc.size() > 0 && q_cyc[0] < cyc + 1 - int'(LAT)) begin
         void'(q_cyc.pop_front());
         void'(q_row.pop_front());
      end
   endtask

   task automatic reset_dut(input string tag);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      s_valid  = 1'b1;
      m_credit = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check({tag, "_s_ready"},   32'(s_ready),    32'd0);
         check({tag, "_core_load"}, 32'(core_load),  32'd0);
         check({tag, "_m_valid"},   32'(m_valid),    32'd0);
         check({tag, "_m_first"},   32'(m_first),    32'd0);
         check({tag, "_m_last"},    32'(m_last),     32'd0);
         check({tag, "_blk_done"},  32'(blk_done),   32'd0);
         check({tag, "_busy"},      32'(busy),       32'd0);
         check({tag, "_err"},       32'(err_credit), 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      rst     = 1'b1;
      s_valid = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      reset_dut("rst0");

      // Back-to-back / overlapping blocks with credits echoed from outputs
      repeat (20) step(1'b1, 2);
      repeat (6)  step(1'b0, 2);

      // Credit exhaustion then a single returned credit
      repeat (6) step(1'b1, 0);
      step(1'b1, 1);
      repeat (3) step(1'b1, 0);
      repeat (4) step(1'b0, 1);

      // Credit returned with counter full -> sticky error through later traffic
      step(1'b0, 1);
      repeat (150) step(1'($urandom_range(0, 1)), 3);

      // Reset mid-block: 5 rows taken, later rows still in flight
      reset_dut("rst1");
      repeat (5) step(1'b1, 2);
      reset_dut("rst_mid");
      repeat (12) step(1'b1, 2);
      repeat (6)  step(1'b0, 2);

      // Random traffic with bursts and drains
      repeat (300) step(1'($urandom_range(0, 3) != 0), 3);
      repeat (10)  step(1'b0, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dct8_sched.md
# dct8_sched

Row scheduler and flow controller for the 8-point 1-D DCT core (`dct8puntos`). It accepts rows of an 8×8 block through a valid/ready handshake and drives the core's `load` strobe. It tracks each row through the core's fixed pipeline latency and tags the core outputs with valid, row index and block boundaries. A credit counter guarantees that the non-stallable core never produces a row the downstream buffer cannot hold.

## Interface
Parameters:
- `LAT` – default 2 – core latency in cycles, from the edge that samples `load` to the cycle in which `y0..y7` are valid; legal range 1..8.
- `ROWS` – default 8 – rows per block.
- `CREDITS` – default 4 – number of downstream buffer entries; legal range 1..15.

Ports:
- `clk` – input – 1 – single clock; all logic is on the rising edge.
- `rst` – input – 1 – asynchronous, active-low reset.
- `s_valid` – input – 1 – upstream presents a row on the core's `x0..x7` inputs.
- `s_ready` – output – 1 – the scheduler can accept a row this cycle.
- `core_load` – output – 1 – drives the core's `load` input.
- `m_valid` – output – 1 – `y0..y7` hold a valid row this cycle.
- `m_row` – output – 3 – row index of the current output row.
- `m_first` – output – 1 – the current output row is row 0.
- `m_last` – output – 1 – the current output row is row `ROWS-1`.
- `m_credit` – input – 1 – one-cycle pulse; the downstream has freed one entry.
- `busy` – output – 1 – a block is partially accepted or rows are still in flight.
- `blk_done` – output – 1 – one-cycle pulse coinciding with `m_last` && `m_valid`.
- `err_credit` – output – 1 – sticky flag: a credit was returned while the counter was already at `CREDITS`.

## Operation
- **Accept.** `acc = s_valid & s_ready`.
  - `s_ready = (credit_cnt != 0) & rst`. It is forced to 0 while reset is asserted.
  - `core_load = acc`, combinationally and in the same cycle.
- **Credit counter.** Width is `$clog2(CREDITS+1)`. Reset value is `CREDITS`.
  - Decrements by 1 on `acc`.
  - Increments by 1 on `m_credit`.
  - Is unchanged when both occur in the same cycle.
  - On `m_credit` at `CREDITS` with no `acc`: the counter holds and `err_credit` is set. `err_credit` clears only on reset.
- **Row counter.** 3 bits, reset 0. Increments on `acc` and wraps from `ROWS-1` to 0. The accepted row's tag is the counter value before the increment.
- **Latency pipeline.** `LAT` stages of {valid, row}, advancing every cycle.
  - Stage 0 loads {`acc`, row tag}.
  - `m_valid` and `m_row` come from the final stage.
  - `m_first = m_valid & (m_row==0)`; `m_last = m_valid & (m_row==ROWS-1)`; `blk_done = m_last`.
- **FSM** (reset state IDLE):
  - IDLE → ACCEPT on `acc`.
  - ACCEPT → DRAIN on an `acc` that takes row `ROWS-1`.
  - DRAIN → IDLE when the pipeline is empty and there is no `acc`.
  - DRAIN → ACCEPT on `acc`, i.e. the next block's row 0. Blocks may overlap, with no bubble.
- `busy = (state != IDLE)`.
- **Reset values.** All outputs are 0 during reset. After reset deasserts, `s_ready` = 1. `err_credit` = 0.
- **Reset mid-block.** All pipeline stages, the row counter and the FSM clear immediately. Credits return to `CREDITS`. Rows in flight are discarded, with no `m_valid`.

## Timing
- A row accepted at edge k appears with `m_valid` = 1 in the cycle following edge k+`LAT`-1, i.e. `LAT` cycles after `core_load`.
- Peak throughput is 1 row per cycle while credits are available. A block takes ≥ `ROWS` cycles to accept, plus `LAT` cycles to drain.
- Credit returned at edge k: `s_ready` can rise in the cycle after edge k. There is no combinational path from `m_credit` to `s_ready`.
- `s_ready` does not depend on `s_valid`.

## Configuration
- `DCT8_SCHED_STATS_EN`
  - Defined: adds output `stall_cnt` [15:0]. It increments, saturating at 16'hFFFF, on every cycle with `s_valid & ~s_ready`. It is cleared by reset and on `blk_done`.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- **Back-to-back block.** `LAT`=2, `CREDITS`=8, `m_credit` pulsed for every output row, `s_valid` held high for 8 cycles.
  - `core_load` is high for 8 consecutive cycles.
  - `m_valid` is high for 8 cycles starting 2 cycles later, with `m_row` 0..7.
  - `m_first` fires on row 0; `m_last` and `blk_done` fire on row 7.
  - `busy` falls 3 cycles after the last accept.
- **Credit exhaustion.** `CREDITS`=4, no `m_credit`, `s_valid` held high.
  - Exactly 4 accepts, then `s_ready` = 0.
  - One `m_credit` pulse produces exactly one further accept, on the next cycle.
- **Simultaneous events.** `acc` and `m_credit` in the same cycle.
  - The credit count is unchanged and `s_ready` stays 1.
- **Overlapping blocks.** 16 consecutive accepts.
  - The FSM goes ACCEPT → DRAIN → ACCEPT with no idle cycle.
  - `m_row` wraps 7 → 0 and `blk_done` pulses twice.
- **Reset mid-block.** `rst` asserted low mid-block, after 5 rows accepted with 2 rows in flight.
  - All outputs are 0 immediately.
  - After release, there is no `m_valid` for the discarded rows, `s_ready` = 1, the credit count equals `CREDITS`, and the first new row has `m_row`=0.
- **Credit error.** `m_credit` pulsed while the counter is at `CREDITS`.
  - `err_credit` goes high and stays high through subsequent normal traffic until reset.
